// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB4 requester: valid/ready command in, single APB transfer out, one-cycle response pulse
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("apb_master: DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic timeout_hit;

  logic                psel_nxt;
  logic                penable_nxt;
  logic                pwrite_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt;
  logic [STRB_W-1:0]   pstrb_nxt;
  logic                busy_nxt;
  logic                rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt;
  logic                rsp_err_nxt;

  // Only IDLE takes a command; reset masks ready so nothing is accepted while held in reset.
  assign cmd_ready = (state == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Count ACCESS wait cycles; cleared in SETUP so every transfer starts from zero.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // The last allowed wait cycle is the one where the count is about to reach the limit;
  // pready in that same cycle still completes normally.
  assign timeout_hit = (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE -> SETUP -> ACCESS -> IDLE, leaving ACCESS on pready or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; APB fields hold unless a new command is captured.
  always_comb begin
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    pstrb_nxt     = pstrb;
    busy_nxt      = busy;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          busy_nxt    = 1'b1;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_write ? cmd_wdata : '0;
          pstrb_nxt   = cmd_write ? cmd_strb  : '0;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          busy_nxt      = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
          rsp_err_nxt   = pslverr;
        end else if (timeout_hit) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          busy_nxt      = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
        end
      end
      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops the bus and discards any in-flight response.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      pstrb     <= pstrb_nxt;
      busy      <= busy_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master against a transfer-level model
module tb_apb_master;

  localparam int TOUT = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_setups = 0;
  int n_cmds   = 0;

  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;

  // Every SETUP cycle seen on the bus is one APB transfer.
  always @(posedge pclk) begin
    if (!preset && psel && !penable) n_setups++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transfer from the requester's view; called at a negedge with the master idle.
  // waits = ACCESS cycles with pready low before completion.
  task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic [31:0] rd,
                      input bit err, input bit hold);
    logic [31:0] e_pwdata;
    logic [3:0]  e_pstrb;
    bit          abort;
    int          last;
    e_pwdata = wr ? wd : 32'h0;
    e_pstrb  = wr ? st : 4'h0;
    abort    = TO_EN && (waits >= TOUT);
    last     = abort ? TOUT - 1 : waits;
    n_cmds++;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    #1;
    check("ready_idle", cmd_ready, 1);
    @(posedge pclk); #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
      cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    end
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;

    @(negedge pclk);
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_busy", busy, 1);
    check("setup_ready", cmd_ready, 0);
    check("setup_rsp_valid", rsp_valid, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, e_pwdata);
    check("setup_pstrb", pstrb, e_pstrb);
    check("held_rdata", rsp_rdata, last_rdata);
    check("held_err", rsp_err, last_err);
    @(posedge pclk);

    for (int k = 0; k <= last; k++) begin
      @(negedge pclk);
      check("acc_psel", psel, 1);
      check("acc_penable", penable, 1);
      check("acc_ready", cmd_ready, 0);
      check("acc_rsp_valid", rsp_valid, 0);
      check("acc_paddr", paddr, addr);
      check("acc_pwdata", pwdata, e_pwdata);
      check("acc_pstrb", pstrb, e_pstrb);
      pready  = (k == waits);
      prdata  = (k == waits) ? rd  : $urandom;
      pslverr = (k == waits) ? err : 1'($urandom);
      @(posedge pclk);
    end

    @(negedge pclk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, abort ? 32'h0 : (wr ? 32'h0 : rd));
    check("rsp_err", rsp_err, abort ? 1'b1 : err);
    check("done_psel", psel, 0);
    check("done_penable", penable, 0);
    check("done_busy", busy, 0);
    check("done_ready", cmd_ready, 1);
    check("idle_paddr", paddr, addr);
    check("idle_pwrite", pwrite, wr);
    check("idle_pwdata", pwdata, e_pwdata);
    last_rdata = abort ? 32'h0 : (wr ? 32'h0 : rd);
    last_err   = abort ? 1'b1 : err;
    cmd_valid  = 1'b0;
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_ready", cmd_ready, 0);
    preset = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);
    @(negedge pclk);

    // Directed cases from the plan, issued back to back.
    xfer(1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xfer(1'b0, 12'h008, 32'h1234_5678, 4'hA, 3, 32'h0000_0060, 1'b0, 1'b0);
    xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1, 32'hCAFE_0042, 1'b1, 1'b0);
    xfer(1'b1, 12'h010, 32'h0BAD_F00D, 4'h3, 2, 32'h0, 1'b0, 1'b1);
    xfer(1'b0, 12'hFFC, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge pclk);
    check("rsp_one_cycle", rsp_valid, 0);

    // Reset in the middle of ACCESS: no response, bus dropped immediately.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_wdata = '0; cmd_strb = '0;
    @(posedge pclk); #1;
    cmd_valid = 1'b0; pready = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("pre_rst_penable", penable, 1);
    #2 preset = 1'b1;
    #1;
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_ready", cmd_ready, 0);
    @(negedge pclk);
    preset = 1'b0;
    last_rdata = '0; last_err = 1'b0;
    #1;
    check("postrst_ready", cmd_ready, 1);
    repeat (3) begin
      @(negedge pclk);
      check("postrst_no_rsp", rsp_valid, 0);
      check("postrst_psel", psel, 0);
    end
    n_cmds++;

    // Randomized traffic; occasional long waits exercise the timeout when it is built in.
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
      xfer(1'($urandom), 12'($urandom), $urandom, 4'($urandom), w, $urandom,
           1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge pclk);
    end

    // Long stalls: abort after TOUT cycles if timeout is built in, otherwise wait it out.
    xfer(1'b0, 12'h040, 32'h0, 4'h0, TOUT + 8, 32'h1111_2222, 1'b0, 1'b0);
    xfer(1'b0, 12'h044, 32'h0, 4'h0, TOUT - 1, 32'h3333_4444, 1'b0, 1'b0);
    xfer(1'b1, 12'h048, 32'h5555_6666, 4'hF, TOUT, 32'h0, 1'b0, 1'b0);

    @(negedge pclk);
    check("transfer_count", n_setups, n_cmds);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
